// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the fetch-address generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  // Which source drives the next PC on a given edge.
  typedef enum logic [2:0] {
    SRC_HOLD  = 3'd0,
    SRC_SEQ   = 3'd1,
    SRC_RAS   = 3'd2,
    SRC_REDIR = 3'd3,
    SRC_TRAP  = 3'd4
  } pc_src_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_1000;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack with a saturating occupancy count.
// The pointer addresses the next slot to write; the top entry sits one below it.
module pc_ras #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [XLEN-1:0] push_addr,
  input  logic            pop,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   top_idx;
  logic            do_pop;

  assign top_idx = ptr_q - 1'b1;
  assign top     = mem[top_idx];
  assign empty   = (cnt_q == '0);
  // A pop on an empty stack is dropped so the pointer never underflows.
  assign do_pop  = pop & ~empty;

  // Pointer and count: push+pop swaps the top in place and leaves both unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push && !do_pop) begin
      ptr_q <= ptr_q + 1'b1;
      if (cnt_q != CW'(RAS_DEPTH)) cnt_q <= cnt_q + 1'b1;
    end else if (do_pop && !push) begin
      ptr_q <= ptr_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage write; overflow simply overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (push) begin
      if (do_pop) mem[top_idx] <= push_addr;
      else        mem[ptr_q]   <= push_addr;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: BOOT/RUN/HALT FSM, fixed-priority next-PC mux, PC register.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned     STEP         = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            halted
);

  pc_state_t       state_q, state_d;
  pc_src_t         src;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ras_top;
  logic            ras_push_en;
  logic            ras_pop_en;

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push_en),
    .push_addr (ras_push_addr),
    .pop       (ras_pop_en),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  // Next-state, next-PC source and RAS enables.
  always_comb begin
    state_d     = state_q;
    src         = SRC_HOLD;
    ras_push_en = 1'b0;
    ras_pop_en  = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (trap_valid)                           src = SRC_TRAP;
        else if (redirect_valid)                  src = SRC_REDIR;
        else if (pc_write && ras_pop && !ras_empty) src = SRC_RAS;
        else if (pc_write)                        src = SRC_SEQ;
        // RAS only moves on an advancing edge; traps/redirects never pop.
        ras_push_en = ras_push & (pc_write | trap_valid | redirect_valid);
        ras_pop_en  = (src == SRC_RAS);
        if (halt) state_d = HALT;
      end
      HALT: begin
        if (trap_valid) begin
          src     = SRC_TRAP;
          state_d = RUN;
        end else if (redirect_valid) begin
          src     = SRC_REDIR;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Next-PC mux.
  always_comb begin
    pc_d = pc_q;
    unique case (src)
      SRC_TRAP:  pc_d = trap_vector;
      SRC_REDIR: pc_d = redirect_target;
      SRC_RAS:   pc_d = ras_top;
      SRC_SEQ:   pc_d = pc_q + XLEN'(STEP);
      default:   pc_d = pc_q;
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = (state_q != BOOT);
  assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_pc_gen;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            pc_write;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic            halt;
  logic            ras_push;
  logic [XLEN-1:0] ras_push_addr;
  logic            ras_pop;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            ras_empty;
  logic            halted;

  pc_gen #(
    .XLEN         (XLEN),
    .RESET_VECTOR (32'h1000),
    .STEP         (4),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_write        (pc_write),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .halt            (halt),
    .ras_push        (ras_push),
    .ras_push_addr   (ras_push_addr),
    .ras_pop         (ras_pop),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .ras_empty       (ras_empty),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0=boot 1=run 2=halt; RAS as a list, newest at the back.
  int              m_mode;
  logic [XLEN-1:0] m_pc;
  logic [XLEN-1:0] m_ras [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [XLEN-1:0] npc;
    logic            popped;
    if (reset) begin
      m_mode = 0;
      m_pc   = 32'h1000;
      m_ras.delete();
      return;
    end
    case (m_mode)
      0: m_mode = 1;
      1: begin
        npc    = m_pc;
        popped = 1'b0;
        if (trap_valid) npc = trap_vector;
        else if (redirect_valid) npc = redirect_target;
        else if (pc_write && ras_pop && m_ras.size() > 0) begin
          npc    = m_ras[m_ras.size()-1];
          popped = 1'b1;
        end else if (pc_write) npc = m_pc + 32'd4;
        if (ras_push && (pc_write || trap_valid || redirect_valid)) begin
          if (popped) m_ras[m_ras.size()-1] = ras_push_addr;
          else begin
            m_ras.push_back(ras_push_addr);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
          end
        end else if (popped) begin
          void'(m_ras.pop_back());
        end
        m_pc = npc;
        if (halt) m_mode = 2;
      end
      default: begin
        if (trap_valid) begin
          m_pc   = trap_vector;
          m_mode = 1;
        end else if (redirect_valid) begin
          m_pc   = redirect_target;
          m_mode = 1;
        end
      end
    endcase
  endtask

  // One clock: advance the model with the applied inputs, then compare all outputs.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("pc", 64'(pc), 64'(m_pc));
    check("pc_valid", 64'(pc_valid), 64'(m_mode != 0));
    check("halted", 64'(halted), 64'(m_mode == 2));
    check("ras_empty", 64'(ras_empty), 64'(m_ras.size() == 0));
  endtask

  task automatic idle();
    reset           = 1'b0;
    pc_write        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    trap_valid      = 1'b0;
    trap_vector     = '0;
    halt            = 1'b0;
    ras_push        = 1'b0;
    ras_push_addr   = '0;
    ras_pop         = 1'b0;
  endtask

  task automatic redirect_to(input logic [XLEN-1:0] a);
    idle();
    redirect_valid  = 1'b1;
    redirect_target = a;
    tick();
    idle();
  endtask

  initial begin
    idle();
    m_mode = 0;
    m_pc   = 32'h1000;

    // Reset then idle.
    reset    = 1'b1;
    pc_write = 1'b1;
    repeat (3) tick();
    check("rst_pc", 64'(pc), 64'h1000);
    check("rst_valid", 64'(pc_valid), 64'h0);
    check("rst_empty", 64'(ras_empty), 64'h1);
    reset = 1'b0;
    tick();
    check("boot_pc", 64'(pc), 64'h1000);
    check("boot_valid", 64'(pc_valid), 64'h1);
    tick();
    check("seq1", 64'(pc), 64'h1004);
    tick();
    check("seq2", 64'(pc), 64'h1008);

    // Stall versus redirect.
    redirect_to(32'h2000);
    repeat (2) tick();
    check("stall", 64'(pc), 64'h2000);
    redirect_valid  = 1'b1;
    redirect_target = 32'h3000;
    tick();
    check("redir_stall", 64'(pc), 64'h3000);
    idle();

    // Priority: trap beats redirect and RAS pop; RAS untouched.
    pc_write      = 1'b1;
    ras_push      = 1'b1;
    ras_push_addr = 32'h55;
    tick();
    idle();
    pc_write        = 1'b1;
    trap_valid      = 1'b1;
    trap_vector     = 32'h80;
    redirect_valid  = 1'b1;
    redirect_target = 32'h9000;
    ras_pop         = 1'b1;
    tick();
    check("prio_pc", 64'(pc), 64'h80);
    check("prio_ras", 64'(ras_empty), 64'h0);
    idle();
    pc_write = 1'b1;
    ras_pop  = 1'b1;
    tick();
    check("prio_ras_top", 64'(pc), 64'h55);
    idle();

    // RAS normal operation and overflow.
    pc_write = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      ras_push      = 1'b1;
      ras_push_addr = 32'(i * 32'h100);
      tick();
    end
    ras_push = 1'b0;
    ras_pop  = 1'b1;
    for (int i = 5; i >= 2; i--) begin
      tick();
      check("ras_pop", 64'(pc), 64'(i * 32'h100));
    end
    check("ras_drained", 64'(ras_empty), 64'h1);
    tick();
    check("ras_underflow", 64'(pc), 64'h204);
    idle();

    // HALT and resume.
    redirect_to(32'h1010);
    pc_write = 1'b1;
    halt     = 1'b1;
    tick();
    check("halt_pc", 64'(pc), 64'h1014);
    check("halt_flag", 64'(halted), 64'h1);
    halt    = 1'b0;
    ras_pop = 1'b1;
    repeat (5) tick();
    check("halt_hold", 64'(pc), 64'h1014);
    idle();
    redirect_to(32'h4000);
    check("resume_pc", 64'(pc), 64'h4000);
    check("resume_flag", 64'(halted), 64'h0);

    // Wrap and mid-run reset.
    redirect_to(32'hFFFF_FFFC);
    pc_write = 1'b1;
    tick();
    check("wrap", 64'(pc), 64'h0);
    ras_push      = 1'b1;
    ras_push_addr = 32'h77;
    halt          = 1'b1;
    tick();
    idle();
    reset = 1'b1;
    tick();
    check("mid_rst_pc", 64'(pc), 64'h1000);
    check("mid_rst_valid", 64'(pc_valid), 64'h0);
    check("mid_rst_empty", 64'(ras_empty), 64'h1);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      reset           = ($urandom_range(0, 99) == 0);
      pc_write        = ($urandom_range(0, 3) != 0);
      trap_valid      = ($urandom_range(0, 15) == 0);
      trap_vector     = $urandom;
      redirect_valid  = ($urandom_range(0, 7) == 0);
      redirect_target = $urandom;
      ras_push        = ($urandom_range(0, 3) == 0);
      ras_push_addr   = $urandom;
      ras_pop         = ($urandom_range(0, 2) == 0);
      // Halt only on plain edges so halt/resume interplay stays unambiguous.
      halt = ($urandom_range(0, 15) == 0) && !trap_valid && !redirect_valid;
      tick();
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator for the multi-cycle core; it succeeds the single-width program counter. It holds the architectural PC in a register and loads it from a parameter reset vector through a BOOT state. It selects the next PC by fixed priority from trap, redirect, return-address prediction and sequential increment. A small circular return-address stack (RAS) supplies predicted return targets, and a HALT state freezes fetch until a trap or redirect arrives.

## Interface
Parameters:
- XLEN, 32, width of PC and all address ports
- RESET_VECTOR, 32'h1000, PC value loaded by reset
- STEP, 4, sequential increment in bytes
- RAS_DEPTH, 4, RAS entries (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- pc_write  in  1  advance enable; low = stall, hold PC
- redirect_valid  in  1  branch/jump resolved taken
- redirect_target  in  XLEN  redirect destination
- trap_valid  in  1  exception/interrupt entry
- trap_vector  in  XLEN  trap handler address
- halt  in  1  request to enter HALT after current update
- ras_push  in  1  call retired; push ras_push_addr
- ras_push_addr  in  XLEN  return address (caller PC + STEP)
- ras_pop  in  1  return detected; predict from RAS top
- pc  out  XLEN  current fetch address
- pc_valid  out  1  pc is a legal fetch address this cycle
- ras_empty  out  1  RAS holds no entries
- halted  out  1  FSM in HALT

## Operation
- FSM states: BOOT, RUN, HALT.
- Reset in any state, including mid-operation:
  - state=BOOT, pc=RESET_VECTOR, RAS count=0, pointer=0
  - outputs: pc_valid=0, halted=0, ras_empty=1
- BOOT → RUN unconditionally on the first clock with reset low; pc is unchanged on that transition.
- RUN, next-PC priority (highest first), evaluated only on an advancing edge:
  1. trap_valid → trap_vector. Overrides stall: taken even when pc_write=0.
  2. redirect_valid → redirect_target. Overrides stall.
  3. pc_write & ras_pop & !ras_empty → RAS top, then pop.
  4. pc_write → pc + STEP, wrapping modulo 2^XLEN.
  5. Otherwise hold.
- ras_pop with RAS empty: fall back to the sequential path. No underflow and no pointer change.
- RUN → HALT when halt=1 on any edge. The PC update of that same edge still occurs.
- HALT:
  - pc held; pc_write and ras_pop ignored
  - trap_valid → pc=trap_vector, state=RUN
  - else redirect_valid → pc=redirect_target, state=RUN
  - trap or redirect in the same cycle as halt: resume takes priority and state stays RUN
- RAS is a circular buffer:
  - push writes at pointer, pointer+1 modulo RAS_DEPTH, count saturates at RAS_DEPTH
  - overflow silently overwrites the oldest entry
- RAS push and pop in the same cycle:
  - pop uses the current top for prediction
  - push then replaces that slot; pointer and count are unchanged
- RAS activity (push/pop) is processed in RUN only, and only when pc_write=1 or a trap/redirect occurs.
- A trap or redirect does not alter RAS contents, except for a simultaneous push.
- Bit widths: every address is XLEN bits, with no sign or zero extension. Misaligned targets pass through unchecked.

## Timing
- All outputs are registered. A new pc is visible the cycle after the qualifying input edge, so latency is 1 cycle.
- pc_valid=1 in RUN and HALT, 0 in BOOT and while reset is high.
- halted is asserted the cycle after the edge that entered HALT.
- ras_empty reflects the count after the edge.
- Inputs are sampled only at posedge clk; there are no combinational input-to-output paths.

## Structure
- Package pc_gen_pkg:
  - typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_t
  - typedef enum of next-PC source {SRC_HOLD, SRC_SEQ, SRC_RAS, SRC_REDIR, SRC_TRAP}, for the bench coverage hook
  - localparam default RESET_VECTOR = 32'h1000
- Sub-module pc_ras:
  - parameters XLEN and RAS_DEPTH
  - ports: push, push_addr, pop, top, empty
  - contains the pointer, saturating count and storage array
- pc_gen holds the FSM, the priority mux and the PC register.

## Test plan
- Reset then idle. Hold reset 3 cycles, release, pc_write=1 → pc: 1000 (pc_valid=0), 1000 (valid=1), 1004, 1008.
- Stall vs. redirect. pc=2000, pc_write=0 for 2 cycles → pc holds 2000. Then redirect_valid=1 with redirect_target=3000 and pc_write=0 → pc=3000 the next cycle.
- Priority. trap_valid, redirect_valid and ras_pop all asserted, trap_vector=80 → pc=80, RAS count unchanged.
- RAS, normal and overflow. Push 100, 200, 300, 400, 500 with RAS_DEPTH=4, then pop ×5 → pcs 500, 400, 300, 200. The fifth pop gives pc_prev+4, and ras_empty=1 after the fourth pop.
- HALT and resume.
  - halt at pc=1010 → pc=1014, halted=1, then held for 5 cycles despite pc_write=1.
  - redirect_target=4000 → pc=4000, halted=0.
- Wrap and mid-run reset.
  - Redirect to FFFFFFFC, then advance → pc=00000000.
  - Assert reset while in HALT → pc=1000, pc_valid=0, ras_empty=1.
